// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-indexed data memory.
// Optional misalignment trapping is enabled by defining MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int unsigned DEPTH = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        req_err;

  // Insert the right-aligned store data into its little-endian lane(s).
  function automatic logic [31:0] merge_store(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] res;
    res = old_w;
    case (size)
      2'b00: begin
        case (lane)
          2'd0:    res[7:0]   = new_w[7:0];
          2'd1:    res[15:8]  = new_w[7:0];
          2'd2:    res[23:16] = new_w[7:0];
          default: res[31:24] = new_w[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) res[31:16] = new_w[15:0];
        else         res[15:0]  = new_w[15:0];
      end
      default: res = new_w;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] w,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   res = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: res = w;
    endcase
    return res;
  endfunction

  always_comb begin
    req_err = (req_size == 2'b11) || ({2'b00, req_addr[31:2]} >= DEPTH_W);
`ifdef MISALIGN_TRAP_EN
    if (req_size == 2'b01 && req_addr[0])          req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
`endif
  end

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    size_d        = size_q;
    uns_d         = uns_q;
    lane_d        = lane_q;
    wdata_d       = wdata_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d     = req_write;
          size_d      = req_size;
          uns_d       = req_unsigned;
          lane_d      = req_addr[1:0];
          wdata_d     = req_wdata;
          rsp_rdata_d = 32'h0;
          if (req_err) begin
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end else begin
            rsp_err_d     = 1'b0;
            mem_address_d = {2'b00, req_addr[31:2]};
            // Full-word stores skip the read; everything else reads first.
            if (req_write && req_size == 2'b10) begin
              mem_wdata_d = req_wdata;
              mem_write_d = 1'b1;
              state_d     = WR;
            end else begin
              mem_read_d = 1'b1;
              state_d    = RD;
            end
          end
        end
      end
      RD: begin
        if (write_q) begin
          mem_wdata_d = merge_store(mem_rdata, wdata_q, size_q, lane_q);
          mem_write_d = 1'b1;
          state_d     = WR;
        end else begin
          rsp_rdata_d = extend_load(mem_rdata, size_q, lane_q, uns_q);
          state_d     = RESP;
        end
      end
      WR: state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      lane_q        <= 2'b00;
      wdata_q       <= 32'h0;
      mem_address_q <= 32'h0;
      mem_wdata_q   <= 32'h0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      rsp_err_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      lane_q        <= lane_d;
      wdata_q       <= wdata_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_valid_q   <= rsp_valid_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign mem_address = mem_address_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: scoreboard of expected responses plus a
// behavioural memory; follows MISALIGN_TRAP_EN when it is defined.
module tb_load_store_unit;

  localparam int DEPTH = 10;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem     [0:15];
  logic [31:0] ref_mem [0:15];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] widx;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [31:0] last_rdata, last_waddr, last_wdat;
  logic        last_err;

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always_comb mem_rdata = (mem_address < 32'(DEPTH)) ? mem[mem_address[3:0]] : 32'h0;

  always @(posedge clk)
    if (mem_write && mem_address < 32'(DEPTH)) mem[mem_address[3:0]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour by shifting/masking; updates ref_mem for stores.
  function automatic exp_t model(input logic w, input logic [1:0] sz, input logic u,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    logic [31:0] word, mask, sh, v;
    bit mis;
    e.widx = {2'b00, a[31:2]};
    mis = TRAP && ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00));
    e.rdata = 32'h0; e.err = 1'b0; e.nrd = 0; e.nwr = 0;
    if (sz == 2'b11 || e.widx >= 32'(DEPTH) || mis) begin
      e.err = 1'b1; e.lat = 1;
      return e;
    end
    word = ref_mem[e.widx[3:0]];
    sh   = (sz == 2'b00) ? 32'(a[1:0]) * 8 : 32'(a[1]) * 16;
    mask = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
    if (!w) begin
      e.lat = 2; e.nrd = 1;
      if (sz == 2'b10) e.rdata = word;
      else begin
        v = (word >> sh) & mask;
        if (!u && sz == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
        if (!u && sz == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
        e.rdata = v;
      end
    end else if (sz == 2'b10) begin
      e.lat = 2; e.nwr = 1;
      ref_mem[e.widx[3:0]] = wd;
    end else begin
      e.lat = 3; e.nrd = 1; e.nwr = 1;
      ref_mem[e.widx[3:0]] = (word & ~(mask << sh)) | ((wd & mask) << sh);
    end
    return e;
  endfunction

  task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd, input int hold);
    exp_t e;
    int lat, nrd, nwr;
    logic [31:0] held;
    bit done;
    sb.push_back(model(w, sz, u, a, wd));
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; done = 0;
    last_waddr = 32'hX; last_wdat = 32'hX;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
      if (mem_read) nrd++;
      if (mem_write) begin nwr++; last_waddr = mem_address; last_wdat = mem_wdata; end
      if (rsp_valid) done = 1;
    end
    e = sb.pop_front();
    chk("rsp_timeout", {31'b0, done}, 32'd1);
    chk("latency", lat, e.lat);
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("read_pulses", nrd, e.nrd);
    chk("write_pulses", nwr, e.nwr);
    chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
    if (e.nwr != 0) begin
      chk("write_addr", last_waddr, e.widx);
      chk("write_data", last_wdat, ref_mem[e.widx[3:0]]);
    end
    last_rdata = rsp_rdata;
    last_err   = rsp_err;
    if (hold > 0) begin
      held = rsp_rdata;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("bp_rdata", rsp_rdata, held);
        chk("bp_ready", {31'b0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("rsp_drop", {31'b0, rsp_valid}, 32'd0);
    if (e.widx < 32'(DEPTH)) chk("mem_word", mem[e.widx[3:0]], ref_mem[e.widx[3:0]]);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 32'hA5A5_0000 + 32'(i) * 32'h0000_1111;
      ref_mem[i] = 32'hA5A5_0000 + 32'(i) * 32'h0000_1111;
    end
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;

    run_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 0);
    chk("tp_word_addr", last_waddr, 32'd2);
    chk("tp_word_data", last_wdat, 32'hDEADBEEF);
    run_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_0055, 0);
    chk("tp_byte_merge", last_wdat, 32'hDEAD55EF);
    run_req(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 0);
    chk("tp_half_signed", last_rdata, 32'hFFFFDEAD);
    run_req(1'b0, 2'b00, 1'b1, 32'hB, 32'h0, 0);
    chk("tp_byte_unsigned", last_rdata, 32'h000000DE);
    run_req(1'b0, 2'b00, 1'b0, 32'h8, 32'h0, 0);
    chk("tp_byte_signed", last_rdata, 32'hFFFFFFEF);
    run_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 0);
    run_req(1'b0, 2'b01, 1'b1, 32'h8, 32'h0, 0);
    run_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234ABCD, 0);
    run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0);
    run_req(1'b0, 2'b10, 1'b0, 32'h28, 32'h0, 0);
    chk("tp_oob_err", {31'b0, last_err}, 32'd1);
    run_req(1'b1, 2'b11, 1'b0, 32'h0, 32'h12345678, 0);
    chk("tp_size_err", {31'b0, last_err}, 32'd1);
    run_req(1'b1, 2'b10, 1'b0, 32'h6, 32'hCAFEF00D, 0);
    run_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 0);
    run_req(1'b0, 2'b01, 1'b0, 32'h5, 32'h0, 0);
    run_req(1'b1, 2'b00, 1'b0, 32'h27, 32'h0000_0080, 0);
    run_req(1'b0, 2'b00, 1'b0, 32'h27, 32'h0, 0);

    rsp_ready = 1'b0;
    run_req(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 5);

    // Reset asserted while the word store is in its write cycle.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0BADF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("wr_before_rst", {31'b0, mem_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("arst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("arst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("arst_mem_address", mem_address, 32'h0);
    chk("arst_mem_wdata", mem_wdata, 32'h0);
    chk("arst_rsp_rdata", rsp_rdata, 32'h0);
    chk("arst_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("arst_mem_kept", mem[4], ref_mem[4]);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
